// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares a single-ported data memory between the CPU load/store path (port 0)
//   and the program loader/debug port (port 1). One access is issued per cycle.
//   Contended cycles alternate round-robin. A port can lock ownership for a burst,
//   but ownership is forcibly released after MAX_HOLD consecutive locked grants
//   while the other port waits.
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   req/lock/we/addr/wdata 0,1  requester side (held stable until gnt)
//   gnt0/gnt1             access issued this cycle (combinational)
//   rvalid0/1, rdata0/1   read response, one cycle after the granting cycle
//   cpu_stall             CPU request not served this cycle
//   mem_en/we/addr/wdata  memory command; mem_rdata returns the cycle after a read
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_LOCK0, OWN_LOCK1} own_t;

  own_t              own, own_nxt;
  logic              rr_ptr, rr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              rd_pend0, rd_pend1;
  logic [DATA_W-1:0] rdata_q0, rdata_q1;

  logic any_win;   // some port is granted this cycle
  logic win;       // index of the granted port
  logic ovr;       // starvation override forced the grant away from the owner
  logic hold_max;
  logic req_other;
  logic lock_win;

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    if (v == HOLD_W'(MAX_HOLD)) return v;
    return v + HOLD_W'(1);
  endfunction

  assign hold_max = (hold_cnt == HOLD_W'(MAX_HOLD));

  // Winner selection and next-state
  always_comb begin
    any_win   = 1'b0;
    win       = 1'b0;
    ovr       = 1'b0;
    own_nxt   = own;
    rr_nxt    = rr_ptr;
    hold_nxt  = '0;
    req_other = 1'b0;
    lock_win  = 1'b0;

    case (own)
      OWN_LOCK0: begin
        if (hold_max && req1) begin
          any_win = 1'b1; win = 1'b1; ovr = 1'b1;
        end else if (req0) begin
          any_win = 1'b1; win = 1'b0;
        end else if (req1) begin
          any_win = 1'b1; win = 1'b1;
        end
      end
      OWN_LOCK1: begin
        if (hold_max && req0) begin
          any_win = 1'b1; win = 1'b0; ovr = 1'b1;
        end else if (req1) begin
          any_win = 1'b1; win = 1'b1;
        end else if (req0) begin
          any_win = 1'b1; win = 1'b0;
        end
      end
      default: begin
        if (req0 && req1) begin
          any_win = 1'b1; win = rr_ptr;
        end else if (req0) begin
          any_win = 1'b1; win = 1'b0;
        end else if (req1) begin
          any_win = 1'b1; win = 1'b1;
        end
      end
    endcase

    // No access may be issued while reset is held.
    if (!rst) any_win = 1'b0;

    req_other = win ? req0 : req1;
    lock_win  = win ? lock1 : lock0;

    if (any_win) begin
      if (ovr || !lock_win) own_nxt = OWN_NONE;
      else                  own_nxt = win ? OWN_LOCK1 : OWN_LOCK0;
      if (own == OWN_NONE || ovr) rr_nxt = ~win;
      // A locked grant with the other port waiting counts toward the hold limit;
      // the first grant of a fresh ownership counts as one.
      if (!ovr && lock_win && req_other) begin
        if (own == (win ? OWN_LOCK1 : OWN_LOCK0)) hold_nxt = sat_inc(hold_cnt);
        else                                      hold_nxt = HOLD_W'(1);
      end
    end else begin
      own_nxt = OWN_NONE;
      if (own == OWN_LOCK0 && lock0) own_nxt = OWN_LOCK0;
      if (own == OWN_LOCK1 && lock1) own_nxt = OWN_LOCK1;
    end
  end

  assign gnt0      = any_win & ~win;
  assign gnt1      = any_win & win;
  assign cpu_stall = req0 & ~gnt0;
  assign mem_en    = any_win;
  assign mem_we    = any_win & (win ? we1 : we0);
  assign mem_addr  = any_win ? (win ? addr1 : addr0) : '0;
  assign mem_wdata = any_win ? (win ? wdata1 : wdata0) : '0;

  // Read response: pending flag is the valid; data bypasses from memory while
  // valid and is held afterwards until the next read to that port.
  assign rvalid0 = rd_pend0;
  assign rvalid1 = rd_pend1;
  assign rdata0  = rd_pend0 ? mem_rdata : rdata_q0;
  assign rdata1  = rd_pend1 ? mem_rdata : rdata_q1;

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own      <= OWN_NONE;
      rr_ptr   <= 1'b0;
      hold_cnt <= '0;
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
      rdata_q0 <= '0;
      rdata_q1 <= '0;
    end else begin
      own      <= own_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
      rd_pend0 <= gnt0 & ~we0;
      rd_pend1 <= gnt1 & ~we1;
      if (rd_pend0) rdata_q0 <= mem_rdata;
      if (rd_pend1) rdata_q1 <= mem_rdata;
    end
  end

endmodule
